// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: address width, PC defaults, PC-generator state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] TRAP_PC_DEF  = 32'h0000_0100;
  localparam logic [ADDR_W-1:0] PC_STEP_DEF  = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } pc_state_t;

endpackage

// File: rtl/m_npc_sel.sv
// Next-PC select: jump > branch > stall-hold > sequential, plus redirect-target alignment check.
// Latency: purely combinational, registered by m_pc_gen.
// Backpressure: stall holds the PC; redirects override stall.
// Optional: PC_ALIGN_CHECK_EN sends misaligned redirect targets to TRAP_PC.
import cpu_pkg::*;

module m_npc_sel #(
  parameter logic [ADDR_W-1:0] PC_STEP = PC_STEP_DEF,
  parameter logic [ADDR_W-1:0] TRAP_PC = TRAP_PC_DEF
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] npc,
  output logic              redirect,
  output logic              bad_target
);

  logic [ADDR_W-1:0] target;

`ifndef PC_ALIGN_CHECK_EN
  // Trap vector only matters when the alignment check is built in.
  logic unused_trap_pc;
  assign unused_trap_pc = ^TRAP_PC;
`endif

  // Pick the redirect target (jump wins), then apply the priority chain.
  always_comb begin
    redirect   = jump_en | branch_taken;
    target     = jump_en ? jump_target : branch_target;
    bad_target = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    if (redirect && (target[1:0] != 2'b00)) begin
      bad_target = 1'b1;
      target     = TRAP_PC;
    end
`endif
    if (redirect)
      npc = target;
    else if (stall)
      npc = pc;
    else
      npc = pc + PC_STEP;
  end

endmodule

// File: rtl/m_pc_gen.sv
// PC generator: holds fetch PC for the sync ROM, tracks the PC/valid of the word on the ROM output.
// Latency: pc = target one edge after a redirect; first valid target word one edge later.
// Backpressure: stall re-presents the same address (word repeats, stays valid); redirects win.
// Optional: PC_ALIGN_CHECK_EN traps misaligned redirect targets to TRAP_PC and pulses misalign.
import cpu_pkg::*;

module m_pc_gen #(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [ADDR_W-1:0] PC_STEP  = PC_STEP_DEF,
  parameter logic [ADDR_W-1:0] TRAP_PC  = TRAP_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic [15:0]       flush_cnt,
  output logic              misalign
);

  pc_state_t         state;
  logic [ADDR_W-1:0] npc;
  logic              redirect;
  logic              bad_target;

  m_npc_sel #(
    .PC_STEP (PC_STEP),
    .TRAP_PC (TRAP_PC)
  ) u_npc_sel (
    .pc            (pc),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .npc           (npc),
    .redirect      (redirect),
    .bad_target    (bad_target)
  );

  // PC/ROM-alignment registers plus the boot/run/flush FSM; valid follows the state entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      inst_pc    <= RESET_PC;
      inst_valid <= 1'b0;
      flush_cnt  <= 16'h0000;
      misalign   <= 1'b0;
      state      <= S_BOOT;
    end else begin
      pc       <= npc;
      inst_pc  <= pc;
      misalign <= bad_target;
      if (redirect && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
      case (state)
        S_BOOT, S_RUN, S_FLUSH: begin
          if (redirect) begin
            state      <= S_FLUSH;
            inst_valid <= 1'b0;
          end else begin
            state      <= S_RUN;
            inst_valid <= 1'b1;
          end
        end
        default: begin
          state      <= S_BOOT;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
